choice_capture: RTL and testbench

Front-end that turns the two raw player buttons into a clean stream of choice bits for the bit-predictor core. Each button is synchronised and debounced, and each debounced press becomes one queued bit: k1 gives 1 and k2 gives 0. Bits are delivered to the predictor over a valid/ready handshake, so no press is lost while the predictor is mid-update. The block sits between the GPIO pins and the predictor's input.

---
 rtl/balls_pkg.sv | 12 +
 rtl/button_debounce.sv | 51 +++++
 rtl/choice_capture.sv | 141 ++++++++++++++
 tb/tb_choice_capture.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/balls_pkg.sv
// Shared definitions for the bit-predictor front-end and core: choice-bit type,
// choice encodings and the default debounce length.
package balls_pkg;

  typedef logic choice_bit_t;

  localparam choice_bit_t CHOICE_ONE  = 1'b1;
  localparam choice_bit_t CHOICE_ZERO = 1'b0;

  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-FF synchroniser, registered polarity normalisation (pressed=1),
// stable-state debounce counter and a single-cycle press pulse on released->pressed.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          PIN_IDLE = BUTTON_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The flip is decided one cycle ahead so the press pulse lines up with the edge
  // on which the stable state changes.
  assign w_flip  = (r_level != r_stable) && (r_cnt == CNT_LAST);
  assign o_press = w_flip && r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= PIN_IDLE;
      r_sync2  <= PIN_IDLE;
      r_level  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_level <= BUTTON_ACTIVE_LOW ? ~r_sync2 : r_sync2;
      if (r_level == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_level;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/choice_capture.sv
// Debounced k1/k2 presses become queued choice bits (k1=1, k2=0) for the predictor.
// CHOICE_CAPTURE_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module choice_capture
  import balls_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
  parameter int FIFO_DEPTH        = 4,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        k1,
  input  logic        k2,
  output choice_bit_t choice_bit,
  output logic        choice_valid,
  input  logic        choice_ready,
  output logic        overflow,
  output logic        conflict
);

  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (FIFO_DEPTH >= 2) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("choice_capture: DEBOUNCE_CYCLES>=2 and power-of-two FIFO_DEPTH>=2 required");
  end

  logic        w_p1;
  logic        w_p2;
  logic        w_both;
  logic        w_event;
  choice_bit_t w_ev_bit;
  logic        w_read;
  logic        w_full;
  logic        w_write;
  logic        w_nonempty_next;
  choice_bit_t w_head_next;

  logic        r_valid;
  choice_bit_t r_bit;
  logic        r_overflow;
  logic        r_conflict;

  button_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_deb_k1 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .i_pin  (k1),
    .o_press(w_p1)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_deb_k2 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .i_pin  (k2),
    .o_press(w_p2)
  );

  assign w_both   = w_p1 & w_p2;
  assign w_event  = w_p1 ^ w_p2;
  assign w_ev_bit = w_p1 ? CHOICE_ONE : CHOICE_ZERO;

  // Handshake: choice_bit is meaningful only while choice_valid is high; a transfer
  // happens on an edge where choice_valid && choice_ready, and ready alone does nothing.
  assign w_read  = r_valid & choice_ready;
  assign w_write = w_event & (~w_full | w_read);

`ifdef CHOICE_CAPTURE_FIFO_EN
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(FIFO_DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_rd_next;
  choice_bit_t r_mem [FIFO_DEPTH];

  assign w_full          = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
  assign w_rd_next       = r_rd_ptr + {{AW{1'b0}}, w_read};
  assign w_nonempty_next = (r_wr_ptr != w_rd_next);
  assign w_head_next     = r_mem[w_rd_next[AW-1:0]];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= CHOICE_ZERO;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_ev_bit;
        r_wr_ptr                <= r_wr_ptr + (AW + 1)'(1);
      end
      r_rd_ptr <= w_rd_next;
    end
  end
`else
  logic        r_hold_full;
  choice_bit_t r_hold_bit;

  assign w_full          = r_hold_full;
  assign w_nonempty_next = r_hold_full & ~w_read;
  assign w_head_next     = r_hold_bit;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_bit  <= CHOICE_ZERO;
    end else if (w_write) begin
      r_hold_full <= 1'b1;
      r_hold_bit  <= w_ev_bit;
    end else if (w_read) begin
      r_hold_full <= 1'b0;
    end
  end
`endif

  // The output view excludes this cycle's write, so a fresh entry surfaces one edge later.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_bit      <= CHOICE_ZERO;
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_valid    <= w_nonempty_next;
      r_bit      <= w_nonempty_next ? w_head_next : CHOICE_ZERO;
      r_overflow <= w_event & w_full & ~w_read;
      r_conflict <= w_both;
    end
  end

  assign choice_valid = r_valid;
  assign choice_bit   = r_bit;
  assign overflow     = r_overflow;
  assign conflict     = r_conflict;

endmodule

// File: tb/tb_choice_capture.sv
// Directed bench for choice_capture with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, active-low buttons.
// Expectations follow whichever queue build CHOICE_CAPTURE_FIFO_EN selects.
module tb_choice_capture;

`ifdef CHOICE_CAPTURE_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic k1;
  logic k2;
  logic choice_bit;
  logic choice_valid;
  logic choice_ready;
  logic overflow;
  logic conflict;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int n_ov;
  int n_cf;

  choice_capture #(
    .DEBOUNCE_CYCLES  (4),
    .FIFO_DEPTH       (4),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .k1          (k1),
    .k2          (k2),
    .choice_bit  (choice_bit),
    .choice_valid(choice_valid),
    .choice_ready(choice_ready),
    .overflow    (overflow),
    .conflict    (conflict)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers: every step ends 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (choice_valid && choice_ready) got_q.push_back(choice_bit);
      if (overflow) n_ov++;
      if (conflict) n_cf++;
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    n_ov = 0;
    n_cf = 0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    k1           = 1'b1;
    k2           = 1'b0;
    choice_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      k1 = ~k1;
      k2 = ~k2;
      checks++;
      if ({choice_valid, choice_bit, overflow, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got v/b/ov/cf=%b required 0000", i,
                 {choice_valid, choice_bit, overflow, conflict});
      end
    end
    k1 = 1'b1;
    k2 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    clear_obs();
    collect(15);
    checks++;
    if (got_q.size() != 0 || n_ov != 0 || n_cf != 0) begin
      errors++;
      $display("FAIL reset_release_quiet: got transfers=%0d ov=%0d cf=%0d required 0/0/0",
               got_q.size(), n_ov, n_cf);
    end
  endtask

  task automatic test_clean_k1();
    choice_ready = 1'b1;
    k1 = 1'b0;
    tick(7);
    checks++;
    if (choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL k1_early_E0+6: got valid=%b required 0", choice_valid);
    end
    tick(1);
    checks++;
    if (choice_valid !== 1'b1 || choice_bit !== 1'b1) begin
      errors++;
      $display("FAIL k1_latency_E0+7: got valid=%b bit=%b required 1 1", choice_valid, choice_bit);
    end
    tick(1);
    checks++;
    if (choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL k1_single_cycle: got valid=%b required 0", choice_valid);
    end
    clear_obs();
    collect(30);
    k1 = 1'b1;
    collect(30);
    checks++;
    if (got_q.size() != 0 || n_ov != 0 || n_cf != 0) begin
      errors++;
      $display("FAIL k1_hold_release: got transfers=%0d ov=%0d cf=%0d required 0/0/0",
               got_q.size(), n_ov, n_cf);
    end
  endtask

  task automatic test_bounce();
    choice_ready = 1'b1;
    clear_obs();
    k2 = 1'b0;
    collect(3);
    k2 = 1'b1;
    collect(2);
    k2 = 1'b0;
    collect(25);
    k2 = 1'b1;
    collect(25);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d events required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_bit: got %b required 0", got_q[0]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    int exp_ov;
    choice_ready = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      clear_obs();
      if (p % 2 == 0) k1 = 1'b0;
      else            k2 = 1'b0;
      collect(10);
      k1 = 1'b1;
      k2 = 1'b1;
      collect(10);
      if (FIFO_BUILD) exp_ov = (p == 4) ? 1 : 0;
      else            exp_ov = (p == 0) ? 0 : 1;
      if (exp_ov == 0) exp_q.push_back((p % 2 == 0) ? 1'b1 : 1'b0);
      checks++;
      if (n_ov != exp_ov) begin
        errors++;
        $display("FAIL fill_overflow press %0d: got %0d pulses required %0d", p, n_ov, exp_ov);
      end
    end
    choice_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (choice_valid !== 1'b1 || choice_bit !== exp_q[i]) begin
        errors++;
        $display("FAIL drain[%0d]: got valid=%b bit=%b required 1 %b", i,
                 choice_valid, choice_bit, exp_q[i]);
      end
      tick(1);
    end
    checks++;
    if (choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b required 0", choice_valid);
    end
  endtask

  task automatic test_conflict();
    choice_ready = 1'b1;
    k1 = 1'b0;
    k2 = 1'b0;
    tick(6);
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_early_E0+5: got %b required 0", conflict);
    end
    tick(1);
    checks++;
    if (conflict !== 1'b1 || choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL conflict_E0+6: got cf=%b valid=%b required 1 0", conflict, choice_valid);
    end
    tick(1);
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_pulse_width: got %b required 0", conflict);
    end
    clear_obs();
    collect(20);
    k1 = 1'b1;
    k2 = 1'b1;
    collect(20);
    checks++;
    if (got_q.size() != 0 || n_cf != 0 || n_ov != 0) begin
      errors++;
      $display("FAIL conflict_after: got transfers=%0d cf=%0d ov=%0d required 0/0/0",
               got_q.size(), n_cf, n_ov);
    end
  endtask

  task automatic test_reset_mid();
    choice_ready = 1'b0;
    k1 = 1'b0;
    collect(10);
    k1 = 1'b1;
    collect(10);
    k2 = 1'b0;
    collect(10);
    k2 = 1'b1;
    collect(10);
    checks++;
    if (choice_valid !== 1'b1 || choice_bit !== 1'b1) begin
      errors++;
      $display("FAIL mid_queued: got valid=%b bit=%b required 1 1", choice_valid, choice_bit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got valid=%b required 0", choice_valid);
    end
    #2;
    rst_n = 1'b1;
    tick(1);
    choice_ready = 1'b1;
    clear_obs();
    collect(10);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL mid_queue_empty: got %0d transfers required 0", got_q.size());
    end
    k1 = 1'b0;
    tick(7);
    checks++;
    if (choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_early_E0+6: got valid=%b required 0", choice_valid);
    end
    tick(1);
    checks++;
    if (choice_valid !== 1'b1 || choice_bit !== 1'b1) begin
      errors++;
      $display("FAIL mid_latency_E0+7: got valid=%b bit=%b required 1 1", choice_valid, choice_bit);
    end
    tick(1);
    k1 = 1'b1;
    clear_obs();
    collect(20);
    checks++;
    if (choice_valid !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL mid_tail: got valid=%b transfers=%0d required 0 0", choice_valid, got_q.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    k1           = 1'b1;
    k2           = 1'b1;
    choice_ready = 1'b0;
    n_ov         = 0;
    n_cf         = 0;
    test_reset();
    test_clean_k1();
    test_bounce();
    test_fill_overflow();
    test_conflict();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
